// File: rtl/usb_rxd.sv
// usb_rxd: serial-to-byte receiver for the single-wire collect-side USB link.
//
// Samples the fire-framed bit stream one bit per clock, hunts for the sync
// byte, then assembles payload bytes MSB first. Every assembled byte is held
// for one byte-time before it is emitted, so the trailing guard byte of each
// frame is never emitted. At end of frame the guard byte and byte alignment
// are checked and the emitted byte count is reported.
//
// Ports:
//   clk        single clock, inputs sampled on the rising edge
//   rst        asynchronous active-low reset
//   fire       frame-active qualifier from the line
//   din        serial data bit, meaningful while fire=1
//   dout       payload byte, valid while dvalid=1
//   dvalid     one-cycle strobe per payload byte (no backpressure)
//   fs         one-cycle pulse when sync is found
//   fd         one-cycle pulse at end of frame; nbyte/err valid with it
//   nbyte      payload bytes emitted in the frame just ended (saturating)
//   err        frame error flag, valid with fd
//   dbg_state  current FSM state (IDLE=0, HUNT=1, RECV=2, DONE=3)
//
// Handshake: dvalid is a pure strobe. The consumer must take dout in every
// cycle dvalid=1; there is no ready and the receiver never stalls.

module usb_rxd #(
  parameter logic [7:0] SYNC_DATA = 8'h01,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic             din,
  output logic [7:0]       dout,
  output logic             dvalid,
  output logic             fs,
  output logic             fd,
  output logic [CNT_W-1:0] nbyte,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [7:0]       sr;       // shift register, newest bit in bit 0
  logic [3:0]       hcnt;     // bits sampled while hunting, saturates at 8
  logic [2:0]       bcnt;     // bit position within the current payload byte
  logic [7:0]       pend;     // last complete byte, held back one byte-time
  logic             pend_v;
  logic [CNT_W-1:0] cnt;      // bytes emitted so far in this frame
  logic             err_q;    // error verdict waiting for the fd pulse

  logic [7:0] sr_next;

  assign sr_next   = {sr[6:0], din};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sr     <= 8'h00;
      hcnt   <= 4'd0;
      bcnt   <= 3'd0;
      pend   <= 8'h00;
      pend_v <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
      dout   <= 8'h00;
      dvalid <= 1'b0;
      fs     <= 1'b0;
      fd     <= 1'b0;
      nbyte  <= '0;
      err    <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      fs     <= 1'b0;
      fd     <= 1'b0;
      case (state)
        IDLE: begin
          bcnt   <= 3'd0;
          pend   <= 8'h00;
          pend_v <= 1'b0;
          cnt    <= '0;
          err_q  <= 1'b0;
          if (fire) begin
            // The first frame bit is taken here so no bit is lost on entry.
            sr    <= {7'b0, din};
            hcnt  <= 4'd1;
            state <= HUNT;
          end else begin
            sr   <= 8'h00;
            hcnt <= 4'd0;
          end
        end

        HUNT: begin
          if (fire) begin
            sr <= sr_next;
            if (hcnt != 4'd8) hcnt <= hcnt + 4'd1;
            // hcnt >= 7 means at least 8 bits including the one sampled now.
            if (hcnt >= 4'd7 && sr_next == SYNC_DATA) begin
              fs    <= 1'b1;
              bcnt  <= 3'd0;
              state <= RECV;
            end
          end else begin
            err_q <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end

        RECV: begin
          if (fire) begin
            sr   <= sr_next;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              // A new byte is complete: release the previously held one.
              if (pend_v) begin
                dout   <= pend;
                dvalid <= 1'b1;
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
              end
              pend   <= sr_next;
              pend_v <= 1'b1;
            end
          end else begin
            // The held byte is the guard: it must exist, be zero, and the
            // frame must have closed on a byte boundary.
            err_q <= (bcnt != 3'd0) || !pend_v || (pend != 8'h00);
            state <= DONE;
          end
        end

        DONE: begin
          fd    <= 1'b1;
          nbyte <= cnt;
          err   <= err_q;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rxd.sv
// tb_usb_rxd: bench for usb_rxd.
//
// A reference model works on the whole frame as a bit list: it locates the
// sync byte, cuts the rest into bytes, and derives the emitted bytes, their
// strobe cycles, the fs cycle and the fd verdict. Those expectations go into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// strobes dvalid, fs or fd.

module tb_usb_rxd;

  localparam logic [7:0] SYNC = 8'h01;
  localparam int         NMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fire = 1'b0;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       dvalid;
  logic       fs;
  logic       fd;
  logic [7:0] nbyte;
  logic       err;
  logic [1:0] dbg_state;

  usb_rxd #(.SYNC_DATA(8'h01), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .fire      (fire),
    .din       (din),
    .dout      (dout),
    .dvalid    (dvalid),
    .fs        (fs),
    .fd        (fd),
    .nbyte     (nbyte),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [39:0] exp_q[$];   // {cycle, byte}
  logic [31:0] fs_q[$];    // cycle
  logic [40:0] fd_q[$];    // {cycle, nbyte, err}

  bit frm[$];              // frame bits in line order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: strobe with nothing expected (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [39:0] e;
    logic [31:0] s;
    logic [40:0] f;
    if (!rst) begin
      check("reset_outputs", 64'({dout, dvalid, fs, fd, nbyte, err}), 64'd0);
    end else begin
      if (dvalid) begin
        if (exp_q.size() == 0) unexpected("dvalid");
        else begin
          e = exp_q.pop_front();
          check("dvalid_byte", 64'(dout), 64'(e[7:0]));
          check("dvalid_cycle", 64'(cyc), 64'(e[39:8]));
        end
      end
      if (fs) begin
        if (fs_q.size() == 0) unexpected("fs");
        else begin
          s = fs_q.pop_front();
          check("fs_cycle", 64'(cyc), 64'(s));
        end
      end
      if (fd) begin
        if (fd_q.size() == 0) unexpected("fd");
        else begin
          f = fd_q.pop_front();
          check("fd_cycle", 64'(cyc), 64'(f[40:9]));
          check("fd_nbyte", 64'(nbyte), 64'(f[8:1]));
          check("fd_err", 64'(err), 64'(f[0]));
        end
      end
    end
  end

  // ---------------- frame builders ----------------
  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) frm.push_back(b[i]);
  endtask

  task automatic add_zeros(input int n);
    for (int i = 0; i < n; i++) frm.push_back(1'b0);
  endtask

  // ---------------- reference model ----------------
  // base: cycle id of the edge that samples frm[0]. Events at or after cut
  // are lost to a reset and are not expected.
  task automatic model_push(input int base, input int cut);
    int n;
    int sa;
    int rem;
    int nfull;
    int left;
    int nb;
    int ev;
    bit e;
    logic [7:0] w;
    logic [7:0] bytes[$];
    n  = frm.size();
    sa = -1;
    for (int i = 7; i < n; i++) begin
      w = 8'h00;
      for (int k = 0; k < 8; k++) w = {w[6:0], frm[i-7+k]};
      if (w == SYNC) begin
        sa = i;
        break;
      end
    end
    ev = base + n + 1;   // fd: first fire=0 sample is edge base+n
    if (sa < 0) begin
      if (ev < cut) fd_q.push_back({32'(ev), 8'd0, 1'b1});
    end else begin
      if (base + sa < cut) fs_q.push_back(32'(base + sa));
      rem   = n - 1 - sa;
      nfull = rem / 8;
      left  = rem % 8;
      for (int k = 0; k < nfull; k++) begin
        w = 8'h00;
        for (int j = 0; j < 8; j++) w = {w[6:0], frm[sa + 1 + 8*k + j]};
        bytes.push_back(w);
      end
      // byte k appears when byte k+1 finishes
      for (int k = 0; k < nfull - 1; k++) begin
        if (base + sa + 8*(k+2) < cut)
          exp_q.push_back({32'(base + sa + 8*(k+2)), bytes[k]});
      end
      e = (left != 0) || (nfull == 0);
      if (nfull > 0 && bytes[nfull-1] != 8'h00) e = 1'b1;
      nb = (nfull > 0) ? nfull - 1 : 0;
      if (nb > NMAX) nb = NMAX;
      if (ev < cut) fd_q.push_back({32'(ev), 8'(nb), e});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input int nbits, input bit abort, input int gap);
    int base;
    int cut;
    @(posedge clk); #1;
    base = cyc + 1;
    cut  = abort ? base + nbits - 1 : 32'h7fffffff;
    model_push(base, cut);
    for (int i = 0; i < nbits; i++) begin
      fire = 1'b1;
      din  = frm[i];
      if (i < nbits - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    fire = 1'b0;
    din  = 1'b0;
    if (abort) begin
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end
    repeat (gap) @(posedge clk);
  endtask

  task automatic nominal;
    frm.delete();
    add_byte(8'h01); add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // nominal frame
    nominal();
    run_frame(frm.size(), 1'b0, 3);

    // long preamble
    frm.delete();
    add_zeros(20); add_byte(8'h01); add_byte(8'hFF); add_byte(8'h00);
    run_frame(frm.size(), 1'b0, 3);

    // truncated frame
    frm.delete();
    add_byte(8'h01); add_byte(8'h55); add_byte(8'h00);
    frm.push_back(1'b1); frm.push_back(1'b0); frm.push_back(1'b1);
    run_frame(frm.size(), 1'b0, 3);

    // corrupt guard
    frm.delete();
    add_byte(8'h01); add_byte(8'h12); add_byte(8'h80);
    run_frame(frm.size(), 1'b0, 3);

    // no sync
    frm.delete();
    add_zeros(30);
    run_frame(frm.size(), 1'b0, 3);

    // sync + guard only
    frm.delete();
    add_byte(8'h01); add_byte(8'h00);
    run_frame(frm.size(), 1'b0, 3);

    // sync without any guard byte
    frm.delete();
    add_byte(8'h01);
    run_frame(frm.size(), 1'b0, 3);

    // reset after 12 payload bits, then a full frame
    nominal();
    run_frame(8 + 12, 1'b1, 3);
    nominal();
    run_frame(frm.size(), 1'b0, 3);

    // byte counter saturation
    frm.delete();
    add_byte(8'h01);
    for (int i = 0; i < 260; i++) add_byte(8'($urandom_range(0, 255)));
    add_byte(8'h00);
    run_frame(frm.size(), 1'b0, 3);

    // randomized frames
    for (int t = 0; t < 25; t++) begin
      frm.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) frm.push_back(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) < 8) add_byte(8'h01);
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) add_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) add_byte(8'($urandom_range(0, 255)));
      else add_byte(8'h00);
      if ($urandom_range(0, 4) == 0)
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) frm.push_back(1'($urandom_range(0, 1)));
      run_frame(frm.size(), 1'b0, int'($urandom_range(2, 6)));
    end

    repeat (20) @(posedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("fs_q_drained", 64'(fs_q.size()), 64'd0);
    check("fd_q_drained", 64'(fd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_rxd.md
# usb_rxd

Serial-to-byte receiver for the single-wire collect-side USB link. Samples the `fire`-framed bit stream produced by the link transmitter, hunts for the sync byte, then assembles payload bytes MSB first and presents them on a byte-wide valid strobe. Each frame ends with 8 guard zeros; the receiver removes them, checks that the frame closed on a byte boundary, and reports the payload byte count. It sits between the line/PHY side and the packet parser.

## Interface
- `SYNC_DATA`, 8'h01, sync pattern preceding payload; last 8 bits sampled in HUNT must equal it.
- `CNT_W`, 8, width of the frame byte counter `nbyte`; saturates at all-ones.
- `clk` input 1: single clock; all inputs sampled on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `fire` input 1: frame-active qualifier from the line, registered in step with `din`.
- `din` input 1: serial data bit, valid when `fire`=1.
- `dout` output 8: received payload byte, valid while `dvalid`=1.
- `dvalid` output 1: one-cycle strobe per payload byte.
- `fs` output 1: one-cycle pulse when sync is found.
- `fd` output 1: one-cycle pulse at end of frame; `nbyte`/`err` are valid with it.
- `nbyte` output CNT_W: payload bytes emitted in the frame just ended.
- `err` output 1: frame error flag, valid with `fd`.

## Operation
- States: IDLE, HUNT, RECV, DONE. Reset forces IDLE.
- IDLE:
  - clear shift register, bit counter, pending flag, and byte counter.
  - `fire`=1 → HUNT, sampling `din` in the same cycle.
- HUNT:
  - each cycle with `fire`=1: `sr <= {sr[6:0], din}`; `hcnt` increments, saturating at 8.
  - Sync hit when `hcnt`≥8 counting this bit and `{sr[6:0],din}`==SYNC_DATA → pulse `fs`, clear `bcnt`, → RECV.
  - `fire`=0 before sync → DONE with `err`=1, `nbyte`=0.
- RECV:
  - each cycle with `fire`=1: shift `din` into `sr`, `bcnt` increments mod 8.
  - When `bcnt` wraps (8th bit), the assembled byte goes into `pend`:
    - if `pend` already held a byte, emit it first: `dout`=old `pend`, `dvalid`=1, `nbyte`+1.
    - set `pend_v`=1.
  - The one-byte hold is what discards the guard byte.
- End of frame (`fire`=0 in RECV) → DONE:
  - `err`=1 if `bcnt`≠0 (truncated byte).
  - `err`=1 if `pend_v`=0 (no guard byte).
  - `err`=1 if `pend`≠8'h00 (corrupt guard).
  - The held byte is dropped, never emitted.
- DONE:
  - pulse `fd` with `nbyte` and `err`; → IDLE unconditionally.
  - `fire`=1 during DONE is ignored; the line holds `fire` low for ≥2 cycles between frames.
- `nbyte` saturates at 2^CNT_W−1; saturation alone does not set `err`.
- A frame with only sync + guard: `nbyte`=0, `err`=0.

## Timing
- Reset values: `dout`=0, `dvalid`=0, `fs`=0, `fd`=0, `nbyte`=0, `err`=0, state IDLE.
- `nbyte`/`err` hold their last values until the next DONE.
- `fs` is registered: it asserts the cycle after the last sync bit is sampled.
- Payload byte k: `dvalid` asserts 1 cycle after the last bit of byte k+1 (or of the guard byte) is sampled, so latency is 9 bit-times from byte k's last bit.
- `fd` asserts 2 cycles after the first sample with `fire`=0.
- `dvalid` and `fd` never assert in the same cycle.
- Throughput: one bit per clock, no stall, no backpressure; the consumer must accept every `dvalid`.
- Asynchronous reset mid-frame aborts immediately with no `fd`. After release, the next `fire` rise starts a fresh hunt.

## Test plan
- Nominal frame:
  - Stimulus: `fire`=1 with bits 00000001, then A5, 3C MSB first, then 00000000, then `fire`=0.
  - Response: `fs` once; `dvalid` with 0xA5 then 0x3C, 8 cycles apart; `fd` with `nbyte`=2, `err`=0.
- Long preamble:
  - Stimulus: 20 leading zeros before 00000001, then payload FF, guard 00.
  - Response: sync found only on the 1 bit; one `dvalid` with 0xFF; `nbyte`=1, `err`=0.
- Truncated frame:
  - Stimulus: sync, payload 0x55, guard 00, then 3 extra bits, then `fire`=0.
  - Response: `dvalid` 0x55; `fd` with `nbyte`=1, `err`=1.
- Corrupt guard:
  - Stimulus: sync, payload 0x12, last byte 0x80, then `fire`=0.
  - Response: 0x12 emitted, 0x80 never emitted; `fd` with `nbyte`=1, `err`=1.
- No sync:
  - Stimulus: `fire` high for 30 cycles of zeros, then low.
  - Response: no `fs`, no `dvalid`; `fd` with `nbyte`=0, `err`=1.
- Reset mid-frame:
  - Stimulus: `rst` low for 1 cycle after 12 payload bits, then a full nominal frame.
  - Response: all outputs 0 during reset, no `fd` for the aborted frame; second frame gives `nbyte`=2, `err`=0.
